// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction-fetch request controller.
package ibex_pkg;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } fetch_req_state_e;

  localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_fetch_outstanding.sv
// In-order tracker of granted-but-unanswered fetch requests, one discard bit per entry.
// Entry 0 is the oldest; a response retires it and the remaining entries shift down.
module ibex_fetch_outstanding #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gnt,
  input  logic                stale,
  input  logic                rvalid,
  input  logic                branch,
  output logic [NUM_REQS-1:0] valid,
  output logic                discard_head
);

  logic [NUM_REQS-1:0] valid_q, discard_q;
  logic [NUM_REQS-1:0] valid_sh, discard_sh, new_slot;
  logic [NUM_REQS-1:0] valid_d, discard_d;
  logic                retire;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    retire     = rvalid & valid_q[0];
    valid_sh   = retire ? (valid_q >> 1) : valid_q;
    discard_sh = retire ? (discard_q >> 1) : discard_q;
    // The entries form a thermometer code; the new entry is its lowest empty slot.
    new_slot   = gnt ? (~valid_sh & ((valid_sh << 1) | NUM_REQS'(1))) : '0;
    valid_d    = valid_sh | new_slot;
    discard_d  = (branch ? valid_sh : discard_sh) | (stale ? new_slot : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      discard_q <= '0;
    end else begin
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  assign valid        = valid_q;
  assign discard_head = discard_q[0];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch bus request controller: issues word fetches, handles redirects, filters stale responses.
// Optional macro IBEX_FETCH_ERR_STOP_EN: stop fetching after an error response until the next branch.
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic [31:0]         fifo_addr_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);

  localparam int unsigned CW = $clog2(2 * NUM_REQS + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(NUM_REQS);

  fetch_req_state_e    state_q;
  logic [31:0]         fetch_addr_q, pend_addr_q;
  logic                pend_q;
  logic [NUM_REQS-1:0] out_valid;
  logic                discard_head;
  logic [CW-1:0]       out_cnt, busy_cnt;
  logic [31:0]         target, addr_int;
  logic                can_issue, req, gnt, stale, push, err_block;

  always_comb begin
    out_cnt  = '0;
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      out_cnt  = out_cnt + CW'(out_valid[i]);
      busy_cnt = busy_cnt + CW'(fifo_busy_i[i]);
    end
  end

  // A branch empties the FIFO, so its occupancy no longer limits the first redirected fetch.
  assign target    = word_align(addr_i);
  assign can_issue = req_i & ~err_block & (out_cnt < MAX_OUT) &
                     (((out_cnt + busy_cnt) < MAX_OUT) | branch_i);
  assign req       = (state_q == WAIT_GNT) | can_issue;
  assign addr_int  = ((state_q == IDLE) && branch_i) ? target : fetch_addr_q;
  assign gnt       = req & instr_gnt_i;
  assign stale     = (state_q == WAIT_GNT) & (branch_i | pend_q);
  assign push      = instr_rvalid_i & out_valid[0] & ~discard_head & ~branch_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (can_issue) begin
            if (instr_gnt_i) begin
              fetch_addr_q <= addr_int + FETCH_ADDR_INCR;
            end else begin
              state_q      <= WAIT_GNT;
              fetch_addr_q <= addr_int;
            end
          end else if (branch_i) begin
            fetch_addr_q <= target;
          end
        end
        WAIT_GNT: begin
          // The address is frozen here; a redirect is parked until the stale request is granted.
          if (instr_gnt_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            if (branch_i)    fetch_addr_q <= target;
            else if (pend_q) fetch_addr_q <= pend_addr_q;
            else             fetch_addr_q <= fetch_addr_q + FETCH_ADDR_INCR;
          end else if (branch_i) begin
            pend_q      <= 1'b1;
            pend_addr_q <= target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IBEX_FETCH_ERR_STOP_EN
  logic err_stop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    err_stop_q <= 1'b0;
    else if (branch_i)            err_stop_q <= 1'b0;
    else if (push && instr_err_i) err_stop_q <= 1'b1;
  end

  assign err_block = err_stop_q & ~branch_i;
`else
  assign err_block = 1'b0;
`endif

  ibex_fetch_outstanding #(
    .NUM_REQS(NUM_REQS)
  ) u_outstanding (
    .clk         (clk_i),
    .rst         (rst_i),
    .gnt         (gnt),
    .stale       (stale),
    .rvalid      (instr_rvalid_i),
    .branch      (branch_i),
    .valid       (out_valid),
    .discard_head(discard_head)
  );

  // Outputs are forced low during reset even though several are combinational paths.
  assign instr_req_o  = ~rst_i & req;
  assign instr_addr_o = rst_i ? '0 : addr_int;
  assign fifo_clear_o = ~rst_i & branch_i;
  assign fifo_addr_o  = rst_i ? '0 : addr_i;
  assign fifo_valid_o = ~rst_i & push;
  assign fifo_rdata_o = rst_i ? '0 : instr_rdata_i;
  assign fifo_err_o   = ~rst_i & instr_err_i;
  assign busy_o       = ~rst_i & (req | (|out_valid));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Self-checking bench for ibex_fetch_req_ctrl: request-gating vector table plus redirect/response sequences.
module tb_ibex_fetch_req_ctrl;

`ifdef IBEX_FETCH_ERR_STOP_EN
  localparam bit ERR_STOP = 1'b1;
`else
  localparam bit ERR_STOP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] addr_i, instr_rdata_i;
  logic [1:0]  fifo_busy_i;
  logic        fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o, busy_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } push_t;
  push_t sb_q[$];

  typedef struct {
    logic        req;
    logic        br;
    logic [31:0] addr;
    logic [1:0]  fb;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_clear;
  } vec_t;
  vec_t vecs[8];

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .addr_i        (addr_i),
    .fifo_busy_i   (fifo_busy_i),
    .fifo_clear_o  (fifo_clear_o),
    .fifo_addr_o   (fifo_addr_o),
    .fifo_valid_o  (fifo_valid_o),
    .fifo_rdata_o  (fifo_rdata_o),
    .fifo_err_o    (fifo_err_o),
    .instr_req_o   (instr_req_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_addr_o  (instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle, then pop the scoreboard on any push.
  task automatic set_in(input logic req, input logic br, input logic [31:0] a, input logic [1:0] fb,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
    push_t exp;
    req_i = req; branch_i = br; addr_i = a; fifo_busy_i = fb;
    instr_gnt_i = gnt; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
    #1;
    if (fifo_valid_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_push", {31'b0, fifo_valid_o}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check("push_rdata", fifo_rdata_o, exp.rdata);
        check("push_err", {31'b0, fifo_err_o}, {31'b0, exp.err});
      end
    end
  endtask

  task automatic expect_push(input logic [31:0] rd, input logic er);
    push_t p;
    p.rdata = rd;
    p.err   = er;
    sb_q.push_back(p);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_in(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 2'b00, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_1002, 2'b11, 1'b1, 32'h0000_1000, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_2003, 2'b00, 1'b0, 32'h0000_2000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'hFFFF_FFFC, 1'b1};

    // Outputs held low under reset even with every input active.
    rst_i = 1'b1;
    set_in(1, 1, 32'h1234_5677, 2'b00, 1, 1, 32'hDEAD_BEEF, 1);
    check("rst_req", {31'b0, instr_req_o}, 32'd0);
    check("rst_addr", instr_addr_o, 32'd0);
    check("rst_valid", {31'b0, fifo_valid_o}, 32'd0);
    check("rst_clear", {31'b0, fifo_clear_o}, 32'd0);
    check("rst_faddr", fifo_addr_o, 32'd0);
    check("rst_rdata", fifo_rdata_o, 32'd0);
    check("rst_err", {31'b0, fifo_err_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);

    // Request gating from a fresh reset, no grant.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_in(vecs[i].req, vecs[i].br, vecs[i].addr, vecs[i].fb, 0, 0, 32'h0, 0);
      check($sformatf("vec%0d_req", i), {31'b0, instr_req_o}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i), instr_addr_o, vecs[i].exp_addr);
      check($sformatf("vec%0d_clear", i), {31'b0, fifo_clear_o}, {31'b0, vecs[i].exp_clear});
      check($sformatf("vec%0d_faddr", i), fifo_addr_o, vecs[i].addr);
      check($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, vecs[i].exp_req});
      @(negedge clk_i);
    end

    // Branch with same-cycle grant, outstanding limit, grant withheld with req_i toggling.
    do_reset();
    set_in(1, 1, 32'h0000_1002, 2'b00, 1, 0, 32'h0, 0);
    check("a_req", {31'b0, instr_req_o}, 32'd1);
    check("a_addr", instr_addr_o, 32'h0000_1000);
    check("a_clear", {31'b0, fifo_clear_o}, 32'd1);
    check("a_faddr", fifo_addr_o, 32'h0000_1002);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("a_next_addr", instr_addr_o, 32'h0000_1004);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    check("a_full_noreq", {31'b0, instr_req_o}, 32'd0);
    check("a_full_busy", {31'b0, busy_o}, 32'd1);
    @(negedge clk_i);
    expect_push(32'hAAAA_0001, 1'b0);
    set_in(1, 0, 32'h0, 2'b00, 0, 1, 32'hAAAA_0001, 0);
    check("a_push1", {31'b0, fifo_valid_o}, 32'd1);
    check("a_retire_noreq", {31'b0, instr_req_o}, 32'd0);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    check("a_reenable", {31'b0, instr_req_o}, 32'd1);
    check("a_reen_addr", instr_addr_o, 32'h0000_1008);
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      set_in(k[0] ? 1'b1 : 1'b0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
      check($sformatf("a_hold%0d_req", k), {31'b0, instr_req_o}, 32'd1);
      check($sformatf("a_hold%0d_addr", k), instr_addr_o, 32'h0000_1008);
      @(negedge clk_i);
    end
    set_in(0, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("a_gnt_addr", instr_addr_o, 32'h0000_1008);
    @(negedge clk_i);
    expect_push(32'hAAAA_0002, 1'b0);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hAAAA_0002, 0);
    @(negedge clk_i);
    expect_push(32'hAAAA_0003, 1'b1);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hAAAA_0003, 1);
    @(negedge clk_i);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hAAAA_0004, 0);
    check("a_idle_rvalid", {31'b0, fifo_valid_o}, 32'd0);
    check("a_idle_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);

    // Branch with two responses outstanding; reset mid-transaction; branch on a retiring response.
    do_reset();
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("b_addr2", instr_addr_o, 32'h0000_0004);
    @(negedge clk_i);
    set_in(0, 1, 32'h0000_3000, 2'b00, 0, 0, 32'h0, 0);
    check("b_clear", {31'b0, fifo_clear_o}, 32'd1);
    @(negedge clk_i);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hBBBB_0001, 0);
    check("b_drop1", {31'b0, fifo_valid_o}, 32'd0);
    @(negedge clk_i);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hBBBB_0002, 0);
    check("b_drop2", {31'b0, fifo_valid_o}, 32'd0);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("b_target", instr_addr_o, 32'h0000_3000);
    @(negedge clk_i);
    expect_push(32'hBBBB_0003, 1'b0);
    set_in(1, 0, 32'h0, 2'b00, 1, 1, 32'hBBBB_0003, 0);
    check("b_push", {31'b0, fifo_valid_o}, 32'd1);
    check("b_addr_after", instr_addr_o, 32'h0000_3004);
    @(negedge clk_i);
    do_reset();
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hBBBB_0004, 0);
    check("b_post_rst_drop", {31'b0, fifo_valid_o}, 32'd0);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    @(negedge clk_i);
    set_in(0, 1, 32'h0000_4000, 2'b00, 0, 1, 32'hBBBB_0005, 0);
    check("b_br_retire_drop", {31'b0, fifo_valid_o}, 32'd0);
    @(negedge clk_i);

    // Branch while waiting for a grant: the stale grant is dropped, fetch resumes at the target.
    do_reset();
    set_in(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    @(negedge clk_i);
    set_in(1, 1, 32'h0000_2000, 2'b00, 0, 0, 32'h0, 0);
    check("c_hold_req", {31'b0, instr_req_o}, 32'd1);
    check("c_hold_addr", instr_addr_o, 32'h0000_0000);
    check("c_clear", {31'b0, fifo_clear_o}, 32'd1);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("c_stale_addr", instr_addr_o, 32'h0000_0000);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("c_target", instr_addr_o, 32'h0000_2000);
    @(negedge clk_i);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hCCCC_0001, 0);
    check("c_stale_drop", {31'b0, fifo_valid_o}, 32'd0);
    @(negedge clk_i);
    expect_push(32'hCCCC_0002, 1'b0);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hCCCC_0002, 0);
    check("c_push", {31'b0, fifo_valid_o}, 32'd1);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("c_target_plus4", instr_addr_o, 32'h0000_2004);
    @(negedge clk_i);

    // Address wrap, then an error response.
    do_reset();
    set_in(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 32'h0, 0);
    check("d_top_addr", instr_addr_o, 32'hFFFF_FFFC);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("d_wrap_addr", instr_addr_o, 32'h0000_0000);
    @(negedge clk_i);
    expect_push(32'hDDDD_0001, 1'b1);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hDDDD_0001, 1);
    @(negedge clk_i);
    expect_push(32'hDDDD_0002, 1'b0);
    set_in(0, 0, 32'h0, 2'b00, 0, 1, 32'hDDDD_0002, 0);
    @(negedge clk_i);
    set_in(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check("d_after_err_req", {31'b0, instr_req_o}, {31'b0, ~ERR_STOP});
    @(negedge clk_i);
    set_in(1, 1, 32'h0000_5000, 2'b00, 1, 0, 32'h0, 0);
    check("d_branch_req", {31'b0, instr_req_o}, 32'd1);
    check("d_branch_addr", instr_addr_o, 32'h0000_5000);
    @(negedge clk_i);
    set_in(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_req_ctrl.md
IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, giving the maximum number of outstanding bus requests (at least 1).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_i, input, 1 bit: fetch enable from the IF stage.
REQ-005 SHALL have ports branch_i (input, 1 bit) and addr_i (input, 32 bits): redirect pulse and its target.
REQ-006 SHALL have port fifo_busy_i, input, NUM_REQS bits: occupancy of the fetch FIFO's upper entries.
REQ-007 SHALL have fifo_clear_o (output, 1 bit) and fifo_addr_o (output, 32 bits): FIFO clear and restart address.
REQ-008 SHALL have FIFO push outputs fifo_valid_o (1 bit), fifo_rdata_o (32 bits) and fifo_err_o (1 bit).
REQ-009 SHALL have bus ports instr_req_o (output, 1), instr_gnt_i (input, 1) and instr_addr_o (output, 32).
REQ-010 SHALL have bus response inputs instr_rvalid_i (1), instr_rdata_i (32) and instr_err_i (1).
REQ-011 SHALL have port busy_o, output, 1 bit: high when a request is pending or any response is outstanding.

Function
REQ-012 SHALL implement an FSM with states IDLE and WAIT_GNT: IDLE->WAIT_GNT when a request issues without a same-cycle grant; WAIT_GNT->IDLE on instr_gnt_i.
REQ-013 SHALL, in IDLE, assert instr_req_o when req_i=1, outstanding count < NUM_REQS, and either (outstanding + popcount(fifo_busy_i)) < NUM_REQS or branch_i=1.
REQ-014 SHALL hold instr_req_o=1 with instr_addr_o unchanged throughout WAIT_GNT, regardless of req_i or branch_i.
REQ-015 SHALL drive word-aligned addresses only: instr_addr_o[1:0]=2'b00.
REQ-016 SHALL, in IDLE with branch_i=1, drive instr_addr_o={addr_i[31:2],2'b00} in that same cycle.
REQ-017 SHALL advance the fetch address by 4 on every grant, with wrap-around modulo 2^32.
REQ-018 SHALL track outstanding responses as a NUM_REQS-deep in-order shift vector with a per-entry discard bit; a grant sets the next entry, rvalid retires entry 0.
REQ-019 SHALL, on branch_i, drive fifo_clear_o=1 and fifo_addr_o=addr_i combinationally, and set the discard bit of every outstanding entry, including a response retiring that cycle.
REQ-020 SHALL, on a branch in WAIT_GNT, store the target and discard the stale request once granted; the next request SHALL use the stored target and the stored target plus 4 thereafter.
REQ-021 SHALL drive fifo_valid_o=instr_rvalid_i & ~discard[0] & ~branch_i, with fifo_rdata_o=instr_rdata_i and fifo_err_o=instr_err_i.
REQ-022 SHALL accept a grant and an rvalid in the same cycle, leaving the outstanding count unchanged.
REQ-023 SHALL ignore instr_rvalid_i when nothing is outstanding.

Reset
REQ-024 SHALL, while rst_i=1, hold: state IDLE, fetch address 0, outstanding and discard vectors 0, pending-branch flag 0.
REQ-025 SHALL, while rst_i=1, hold all outputs at 0: instr_req_o, instr_addr_o, fifo_valid_o, fifo_clear_o, fifo_addr_o, fifo_rdata_o, fifo_err_o, busy_o.
REQ-026 SHALL, after reset deasserts mid-transaction, not forward responses to requests issued before reset.

Configuration
REQ-027 SHALL, with macro IBEX_FETCH_ERR_STOP_EN defined, block new requests after a non-discarded response with instr_err_i=1 until the next branch_i.
REQ-028 SHALL, without IBEX_FETCH_ERR_STOP_EN, keep issuing requests after error responses.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, WAIT_GNT) from ibex_pkg, as fetch_req_state_e.
REQ-030 SHALL take the word-increment constant FETCH_ADDR_INCR = 32'd4 from ibex_pkg.
REQ-031 SHALL contain the outstanding/discard tracker as sub-module ibex_fetch_outstanding, parameterised by NUM_REQS.

Verification
REQ-032 SHALL cover: branch_i to 0x0000_1002 with gnt same cycle -> instr_addr_o=0x1000, fifo_clear_o=1, fifo_addr_o=0x1002, next request 0x1004.
REQ-033 SHALL cover: gnt withheld 3 cycles with req_i toggling -> instr_req_o stays 1 and instr_addr_o is stable for all 3 cycles.
REQ-034 SHALL cover: NUM_REQS=2, two granted, no rvalid -> no third request; one rvalid -> request re-enabled the next cycle.
REQ-035 SHALL cover: branch with 2 responses outstanding -> both rvalids give fifo_valid_o=0; the first post-branch response is pushed.
REQ-036 SHALL cover: branch in WAIT_GNT to 0x2000 -> stale grant discarded, next instr_addr_o=0x2000.
REQ-037 SHALL cover: fetch address 0xFFFF_FFFC granted -> next address 0x0000_0000; error response with IBEX_FETCH_ERR_STOP_EN -> no request until branch_i.
